// File: rtl/vend_change_dispenser_if.sv
// Change-return bus: request from the vend controller, coin handshake to the hopper, result flags.
// master drives requests and coin_ack; slave (the dispenser) drives the coin and status outputs.
interface vend_change_dispenser_if #(
    parameter int AMT_W = 8
);
    logic             start;
    logic [AMT_W-1:0] credit;
    logic [AMT_W-1:0] price;
    logic [2:0]       empty;
    logic             coin_ack;
    logic             coin_valid;
    logic [1:0]       coin_out;
    logic             busy;
    logic             done;
    logic [AMT_W-1:0] paid;
    logic             short;
    logic             fault;
    logic             bad_req;

    modport master (
        output start, credit, price, empty, coin_ack,
        input  coin_valid, coin_out, busy, done, paid, short, fault, bad_req
    );

    modport slave (
        input  start, credit, price, empty, coin_ack,
        output coin_valid, coin_out, busy, done, paid, short, fault, bad_req
    );
endinterface

// File: rtl/vend_change_dispenser.sv
// Pays (credit - price) as greedy 100/50/25c coins; first coin_valid two edges after start, >=2 cycles per coin.
// Each coin is held until coin_ack or ACK_TIMEOUT cycles; a timeout ends the request with fault+short.
module vend_change_dispenser #(
    parameter int ACK_TIMEOUT = 1280,
    parameter int AMT_W       = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    vend_change_dispenser_if.slave  bus
);
    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [AMT_W-1:0] V25  = AMT_W'(25);
    localparam logic [AMT_W-1:0] V50  = AMT_W'(50);
    localparam logic [AMT_W-1:0] V100 = AMT_W'(100);
    localparam logic [1:0] C25  = 2'b00;
    localparam logic [1:0] C50  = 2'b01;
    localparam logic [1:0] C100 = 2'b10;
    localparam logic [1:0] NONE = 2'b11;

    typedef enum logic [1:0] {IDLE, CALC, ISSUE, DONE} state_t;

    state_t           state, state_nxt;
    logic [AMT_W-1:0] rem, paid_q, issue_val;
    logic [TW-1:0]    timer;
    logic             coin_valid_q, short_q, fault_q, bad_q;
    logic [1:0]       coin_q, pick_code;
    logic             pick_ok, timed_out, req_bad;

    assign req_bad   = (bus.credit < bus.price);
    assign timed_out = (timer == TW'(ACK_TIMEOUT - 1));

    // Largest coin that fits the remainder and whose hopper is not empty.
    always_comb begin
        pick_ok   = 1'b1;
        pick_code = NONE;
        if (rem >= V100 && !bus.empty[2])     pick_code = C100;
        else if (rem >= V50 && !bus.empty[1]) pick_code = C50;
        else if (rem >= V25 && !bus.empty[0]) pick_code = C25;
        else                                  pick_ok   = 1'b0;
    end

    always_comb begin
        case (coin_q)
            C25:     issue_val = V25;
            C50:     issue_val = V50;
            C100:    issue_val = V100;
            default: issue_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = req_bad ? DONE : CALC;
            CALC:    state_nxt = pick_ok ? ISSUE : DONE;
            ISSUE:   if (bus.coin_ack) state_nxt = CALC;
                     else if (timed_out) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rem          <= '0;
            paid_q       <= '0;
            timer        <= '0;
            coin_valid_q <= 1'b0;
            coin_q       <= NONE;
            short_q      <= 1'b0;
            fault_q      <= 1'b0;
            bad_q        <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    paid_q <= '0;
                    bad_q  <= req_bad;
                    if (!req_bad) rem <= bus.credit - bus.price;
                end
                CALC: begin
                    if (pick_ok) begin
                        coin_q       <= pick_code;
                        coin_valid_q <= 1'b1;
                        timer        <= '0;
                    end else if (rem != '0) begin
                        short_q <= 1'b1;
                    end
                end
                // An ack on the timeout edge still counts the coin.
                ISSUE: begin
                    if (bus.coin_ack) begin
                        rem          <= rem - issue_val;
                        paid_q       <= paid_q + issue_val;
                        coin_valid_q <= 1'b0;
                        coin_q       <= NONE;
                    end else if (timed_out) begin
                        coin_valid_q <= 1'b0;
                        coin_q       <= NONE;
                        fault_q      <= 1'b1;
                        short_q      <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                DONE: begin
                    short_q <= 1'b0;
                    fault_q <= 1'b0;
                    bad_q   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.busy       = (state != IDLE);
        bus.done       = (state == DONE);
        bus.short      = short_q & (state == DONE);
        bus.fault      = fault_q & (state == DONE);
        bus.bad_req    = bad_q   & (state == DONE);
        bus.paid       = paid_q;
        bus.coin_valid = coin_valid_q;
        bus.coin_out   = coin_q;
    end
endmodule
